// File: rtl/ser32_mux_seq_pkg.sv
// ser32_mux_seq_pkg
// Shared definitions for the sequenced 32:1 serialiser: FSM state encoding,
// word/select widths and the select start value for either bit order.
package ser32_mux_seq_pkg;

  localparam int SEL_W  = 5;
  localparam int WORD_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // First select value of a word: bit 0 when sending LSB first, bit 31 otherwise.
  function automatic logic [SEL_W-1:0] start_sel(input logic lsb_first);
    return lsb_first ? {SEL_W{1'b0}} : {SEL_W{1'b1}};
  endfunction

endpackage

// File: rtl/ser32_mux_seq_mux32.sv
// ser32_mux_seq_mux32
// Behavioural model of the MUX32 primitive: o = I[s].
// Ports:
//   i  [31:0]  data inputs, bit k is mux input Ik
//   s  [4:0]   select {S4..S0}
//   o          selected bit (combinational)
module ser32_mux_seq_mux32
  import ser32_mux_seq_pkg::*;
(
  input  logic [WORD_W-1:0] i,
  input  logic [SEL_W-1:0]  s,
  output logic              o
);

  assign o = i[s];

endmodule

// File: rtl/ser32_mux_seq.sv
// ser32_mux_seq
// Sequenced 32:1 parallel-to-serial stage. Words arrive over valid/ready into
// a shadow register, move into the active register feeding a MUX32, and a
// 5-bit select counter walks the mux one bit per enabled clock. The mux output
// is registered into dout together with valid/first/last framing flags.
// Ports:
//   clk         rising-edge clock
//   resetn      asynchronous active-low reset
//   ce          clock enable; all state (including handshake) frozen when 0
//   in_valid    upstream word valid
//   in_ready    shadow register empty (registered)
//   in_data     word to serialise, bit k -> mux input Ik
//   in_len      bits to send minus 1
//   sel         select currently applied to the mux
//   dout        registered serial bit
//   dout_valid  dout carries a word bit
//   first/last  dout is the first/last bit of a word
module ser32_mux_seq
  import ser32_mux_seq_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ce,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_len,
  output logic [SEL_W-1:0]  sel,
  output logic              dout,
  output logic              dout_valid,
  output logic              first,
  output logic              last
);

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   active_q, active_d;
  logic [SEL_W-1:0]    len_q, len_d;
  logic [SEL_W-1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0]   shadow_q, shadow_d;
  logic [SEL_W-1:0]    shadow_len_q, shadow_len_d;
  logic                shadow_full_q, shadow_full_d;
  logic [SEL_W-1:0]    sel_d;
  logic                dout_d, dout_valid_d, first_d, last_d, in_ready_d;
  logic                accept;
  logic                load;
  logic                mux_out;

  ser32_mux_seq_mux32 u_mux32 (
    .i (active_q),
    .s (sel),
    .o (mux_out)
  );

  assign accept = in_valid & in_ready & ce;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; a missing default would infer a latch.
    state_d       = state_q;
    active_d      = active_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    shadow_len_d  = shadow_len_q;
    shadow_full_d = shadow_full_q;
    sel_d         = sel;
    dout_d        = dout;
    dout_valid_d  = dout_valid;
    first_d       = first;
    last_d        = last;
    in_ready_d    = in_ready;
    load          = 1'b0;

    if (ce) begin
      unique case (state_q)
        IDLE: begin
          dout_d       = IDLE_BIT;
          dout_valid_d = 1'b0;
          first_d      = 1'b0;
          last_d       = 1'b0;
          load         = shadow_full_q;
        end
        SHIFT: begin
          dout_d       = mux_out;
          dout_valid_d = 1'b1;
          first_d      = (cnt_q == len_q);
          last_d       = (cnt_q == '0);
          sel_d        = LSB_FIRST ? sel + SEL_W'(1) : sel - SEL_W'(1);
          if (cnt_q != '0) begin
            cnt_d = cnt_q - SEL_W'(1);
          end else if (shadow_full_q) begin
            // Last bit going out and the next word is waiting: reload on this
            // same edge so the serial stream has no bubble.
            load = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        default: ;
      endcase

      if (load) begin
        active_d = shadow_q;
        len_d    = shadow_len_q;
        cnt_d    = shadow_len_q;
        sel_d    = start_sel(LSB_FIRST);
        state_d  = SHIFT;
      end

      if (accept) begin
        shadow_d     = in_data;
        shadow_len_d = in_len;
      end

      // A refill on the same edge the shadow drains keeps it full.
      shadow_full_d = (shadow_full_q & ~load) | accept;
      in_ready_d    = ~shadow_full_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the word buffers are plain registers, not a RAM, so they are
      // reset with everything else; a mid-word reset discards the word.
      state_q       <= IDLE;
      active_q      <= '0;
      len_q         <= '0;
      cnt_q         <= '0;
      shadow_q      <= '0;
      shadow_len_q  <= '0;
      shadow_full_q <= 1'b0;
      sel           <= start_sel(LSB_FIRST);
      dout          <= IDLE_BIT;
      dout_valid    <= 1'b0;
      first         <= 1'b0;
      last          <= 1'b0;
      in_ready      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed before this edge, independent of statement order.
      state_q       <= state_d;
      active_q      <= active_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      shadow_len_q  <= shadow_len_d;
      shadow_full_q <= shadow_full_d;
      sel           <= sel_d;
      dout          <= dout_d;
      dout_valid    <= dout_valid_d;
      first         <= first_d;
      last          <= last_d;
      in_ready      <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_ser32_mux_seq.sv
// tb_ser32_mux_seq
// Directed bench for ser32_mux_seq. Two instances share stimulus: u_lsb
// (LSB_FIRST=1) and u_msb (LSB_FIRST=0). Inputs change and outputs are
// sampled on the falling edge.
module tb_ser32_mux_seq;

  logic        clk;
  logic        resetn;
  logic        ce;
  logic        in_valid;
  logic [31:0] in_data;
  logic [4:0]  in_len;

  logic        rdy_l, dout_l, vld_l, first_l, last_l;
  logic [4:0]  sel_l;
  logic        rdy_m, dout_m, vld_m, first_m, last_m;
  logic [4:0]  sel_m;

  int total = 0;
  int bad   = 0;

  ser32_mux_seq #(.LSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_lsb (
    .clk (clk), .resetn (resetn), .ce (ce),
    .in_valid (in_valid), .in_ready (rdy_l), .in_data (in_data), .in_len (in_len),
    .sel (sel_l), .dout (dout_l), .dout_valid (vld_l), .first (first_l), .last (last_l)
  );

  ser32_mux_seq #(.LSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_msb (
    .clk (clk), .resetn (resetn), .ce (ce),
    .in_valid (in_valid), .in_ready (rdy_m), .in_data (in_data), .in_len (in_len),
    .sel (sel_m), .dout (dout_m), .dout_valid (vld_m), .first (first_m), .last (last_m)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer one word; returns at the falling edge after the accepting edge.
  task automatic send_word(input logic [31:0] d, input logic [4:0] l);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_len   = l;
    while (!rdy_l && waited < 50) begin
      step();
      waited++;
    end
    total++;
    if (rdy_l !== 1'b1) begin
      bad++;
      $display("FAIL send_ready: in_ready=%b, expected 1 within 50 cycles", rdy_l);
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({dout_l, vld_l, first_l, last_l, rdy_l} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_outs: dout/vld/first/last/rdy=%b expected 00000",
               {dout_l, vld_l, first_l, last_l, rdy_l});
    end
    total++;
    if (sel_l !== 5'd0 || sel_m !== 5'd31) begin
      bad++;
      $display("FAIL reset_sel: lsb=%0d msb=%0d expected 0/31", sel_l, sel_m);
    end
    resetn = 1'b1;
    #1;
    total++;
    if (rdy_l !== 1'b0) begin
      bad++;
      $display("FAIL ready_before_edge: in_ready=%b expected 0", rdy_l);
    end
    @(negedge clk);
    step();
    total++;
    if ({rdy_l, vld_l, dout_l} !== 3'b100 || sel_l !== 5'd0) begin
      bad++;
      $display("FAIL ready_after_release: rdy/vld/dout=%b sel=%0d expected 100 sel=0",
               {rdy_l, vld_l, dout_l}, sel_l);
    end
  endtask

  task automatic test_lsb_word();
    logic [31:0] w;
    w = 32'hA5A5_0F0F;
    send_word(w, 5'd31);
    total++;
    if (vld_l !== 1'b0) begin
      bad++;
      $display("FAIL lsb_lat0: dout_valid=%b expected 0", vld_l);
    end
    step();
    total++;
    if (vld_l !== 1'b0) begin
      bad++;
      $display("FAIL lsb_lat1: dout_valid=%b expected 0", vld_l);
    end
    for (int k = 0; k < 32; k++) begin
      total++;
      if (sel_l !== 5'(k)) begin
        bad++;
        $display("FAIL lsb_sel[%0d]: sel=%0d expected %0d", k, sel_l, k);
      end
      step();
      total++;
      if ({vld_l, dout_l, first_l, last_l} !== {1'b1, w[k], k == 0, k == 31}) begin
        bad++;
        $display("FAIL lsb_bit[%0d]: vld/dout/first/last=%b expected %b", k,
                 {vld_l, dout_l, first_l, last_l}, {1'b1, w[k], k == 0, k == 31});
      end
    end
    step();
    total++;
    if ({vld_l, dout_l, first_l, last_l} !== 4'b0000) begin
      bad++;
      $display("FAIL lsb_idle: vld/dout/first/last=%b expected 0000",
               {vld_l, dout_l, first_l, last_l});
    end
  endtask

  task automatic test_msb_word();
    logic [31:0] w;
    w = 32'h8000_0001;
    send_word(w, 5'd7);
    step();
    for (int k = 0; k < 8; k++) begin
      total++;
      if (sel_m !== 5'(31 - k)) begin
        bad++;
        $display("FAIL msb_sel[%0d]: sel=%0d expected %0d", k, sel_m, 31 - k);
      end
      step();
      total++;
      if ({vld_m, dout_m, first_m, last_m} !== {1'b1, w[31-k], k == 0, k == 7}) begin
        bad++;
        $display("FAIL msb_bit[%0d]: vld/dout/first/last=%b expected %b", k,
                 {vld_m, dout_m, first_m, last_m}, {1'b1, w[31-k], k == 0, k == 7});
      end
    end
    step();
    total++;
    if ({vld_m, dout_m} !== 2'b00) begin
      bad++;
      $display("FAIL msb_idle: vld/dout=%b expected 00", {vld_m, dout_m});
    end
  endtask

  task automatic test_back_to_back();
    // Expected per falling edge after edges E0..E10 (index = edge number).
    logic [10:0] e_rdy, e_vld, e_dout, e_first, e_last;
    e_rdy   = 11'b11111100010;
    e_vld   = 11'b01111111100;
    e_dout  = 11'b00000111100;
    e_first = 11'b00001000100;
    e_last  = 11'b01000100000;
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    in_len   = 5'd3;
    for (int c = 0; c < 11; c++) begin
      step();
      if (c == 0) in_data = 32'h0000_0000;
      if (c == 2) in_valid = 1'b0;
      total++;
      if ({rdy_l, vld_l, dout_l, first_l, last_l} !==
          {e_rdy[c], e_vld[c], e_dout[c], e_first[c], e_last[c]}) begin
        bad++;
        $display("FAIL b2b[%0d]: rdy/vld/dout/first/last=%b expected %b", c,
                 {rdy_l, vld_l, dout_l, first_l, last_l},
                 {e_rdy[c], e_vld[c], e_dout[c], e_first[c], e_last[c]});
      end
    end
  endtask

  task automatic test_ce_stall();
    logic [31:0] w;
    w = 32'h0000_00F0;
    send_word(w, 5'd7);
    step();
    for (int k = 0; k < 8; k++) begin
      if (k == 5) begin
        // Freeze after bit 4 (a 1) has gone out; offer a word that must not land.
        ce       = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        in_len   = 5'd31;
        for (int s = 0; s < 3; s++) begin
          step();
          total++;
          if ({vld_l, dout_l, last_l, rdy_l} !== 4'b1101 || sel_l !== 5'd5) begin
            bad++;
            $display("FAIL ce_hold[%0d]: vld/dout/last/rdy=%b sel=%0d expected 1101 sel=5",
                     s, {vld_l, dout_l, last_l, rdy_l}, sel_l);
          end
        end
        in_valid = 1'b0;
        ce       = 1'b1;
      end
      total++;
      if (sel_l !== 5'(k)) begin
        bad++;
        $display("FAIL ce_sel[%0d]: sel=%0d expected %0d", k, sel_l, k);
      end
      step();
      total++;
      if ({vld_l, dout_l, last_l} !== {1'b1, w[k], k == 7}) begin
        bad++;
        $display("FAIL ce_bit[%0d]: vld/dout/last=%b expected %b", k,
                 {vld_l, dout_l, last_l}, {1'b1, w[k], k == 7});
      end
    end
    for (int s = 0; s < 3; s++) begin
      step();
      total++;
      if ({vld_l, rdy_l} !== 2'b01) begin
        bad++;
        $display("FAIL ce_no_accept[%0d]: vld/rdy=%b expected 01", s, {vld_l, rdy_l});
      end
    end
  endtask

  task automatic test_reset_mid_word();
    send_word(32'hFFFF_FFFF, 5'd31);
    step();
    repeat (10) step();
    #2;
    resetn = 1'b0;
    #1;
    total++;
    if ({vld_l, dout_l, first_l, last_l, rdy_l} !== 5'b00000 || sel_l !== 5'd0) begin
      bad++;
      $display("FAIL reset_async: vld/dout/first/last/rdy=%b sel=%0d expected 00000 sel=0",
               {vld_l, dout_l, first_l, last_l, rdy_l}, sel_l);
    end
    @(negedge clk);
    resetn = 1'b1;
    step();
    send_word(32'h0000_0001, 5'd0);
    step();
    total++;
    if (vld_l !== 1'b0) begin
      bad++;
      $display("FAIL len0_lat: dout_valid=%b expected 0", vld_l);
    end
    step();
    total++;
    if ({vld_l, dout_l, first_l, last_l} !== 4'b1111) begin
      bad++;
      $display("FAIL len0_bit: vld/dout/first/last=%b expected 1111",
               {vld_l, dout_l, first_l, last_l});
    end
    step();
    total++;
    if ({vld_l, dout_l, first_l, last_l} !== 4'b0000) begin
      bad++;
      $display("FAIL len0_idle: vld/dout/first/last=%b expected 0000",
               {vld_l, dout_l, first_l, last_l});
    end
  endtask

  initial begin
    clk      = 1'b0;
    resetn   = 1'b1;
    ce       = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_len   = '0;
    #2 resetn = 1'b0;

    test_reset();
    test_lsb_word();
    test_msb_word();
    test_back_to_back();
    test_ce_stall();
    test_reset_mid_word();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ser32_mux_seq.md
Name: ser32_mux_seq

Overview:
- Sequenced 32:1 parallel-to-serial stage built around the codebase's MUX32 primitive model.
- Accepts 32-bit words over a valid/ready handshake into a two-entry buffer (active + shadow).
- Steps a 5-bit select counter through the mux, emitting one bit per enabled clock.
- Sits directly upstream of the MUX32 instance: it generates the I0..I31 data and S0..S4 selects, and registers the mux output for downstream serial logic (ser/des or bit-bang IO models).

Parameters:
- LSB_FIRST, 1, 1: select counts up from 0 to LEN; 0: counts down from 31 to 31-LEN.
- IDLE_BIT, 1'b0, DOUT value driven when no word is active.

Ports:
- CLK  input  1  rising-edge clock.
- RESETN  input  1  asynchronous active-low reset.
- CE  input  1  clock enable; all state frozen when 0, including handshake acceptance.
- IN_VALID  input  1  upstream word valid.
- IN_READY  output  1  shadow register empty; a transfer occurs when IN_VALID & IN_READY & CE.
- IN_DATA  input  32  word to serialise; bit k drives mux input Ik.
- IN_LEN  input  5  number of bits to send minus 1 (0 = 1 bit, 31 = 32 bits).
- SEL  output  5  current select value {S4..S0} applied to the mux.
- DOUT  output  1  registered serial bit.
- DOUT_VALID  output  1  DOUT carries a word bit this cycle.
- FIRST  output  1  DOUT is the first bit of a word.
- LAST  output  1  DOUT is the last bit of a word.

Behaviour:
- Reset (RESETN=0, asynchronous): state IDLE, both buffers empty, SEL=0 (LSB_FIRST=1) or 31 (LSB_FIRST=0), DOUT=IDLE_BIT, DOUT_VALID=0, FIRST=0, LAST=0, IN_READY=0 while asserted, IN_READY=1 on the first edge after release.
- IN_READY = !shadow_full, registered. Handshake with IN_VALID=1 and IN_READY=0 is ignored; upstream must hold data.
- State IDLE:
  - When the shadow is full, move the shadow into active, set SEL to the start value and the remaining count to IN_LEN, then go to SHIFT.
  - An accepted word reaches the shadow on edge N and active on edge N+1. The first DOUT_VALID appears after edge N+2, giving a latency of 2 enabled cycles from acceptance.
- State SHIFT, each CE cycle:
  - DOUT <= MUX32(active, SEL) and DOUT_VALID <= 1.
  - FIRST <= (count==LEN) and LAST <= (count==0).
  - SEL increments (LSB_FIRST=1) or decrements (LSB_FIRST=0) modulo 32, and count decrements.
- End of word, on the LAST cycle:
  - If the shadow is full, load the next word into active on the same edge. This gives back-to-back output with no gap bubble.
  - Otherwise go to IDLE; DOUT returns to IDLE_BIT and DOUT_VALID to 0 on the next enabled edge.
- Simultaneous load: an upstream accept and a shadow-to-active transfer on the same edge are legal. The shadow is refilled with the new word, and IN_READY stays 1.
- Wrap-around: SEL wraps 31→0 (or 0→31) only when LEN=31. Count never underflows.
- LEN=0: a single bit is emitted, with FIRST and LAST both 1.
- CE=0: SEL, count, buffers, DOUT, flags and IN_READY are held. No handshake completes.
- Reset mid-word: the word is discarded, and outputs take their reset values immediately (asynchronously).
- IN_DATA and IN_LEN are sampled only on an accepted handshake.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, SHIFT=1'b1), SEL width constant 5, word width constant 32, start-select function of LSB_FIRST.
- Sub-module: one MUX32 instance, with I0..I31 wired from the active register and S0..S4 from SEL. Its output is registered here into DOUT.

Test Plan:
- Reset release, no stimulus → DOUT=0, DOUT_VALID=0, SEL=0, IN_READY=1 one cycle after RESETN rises.
- LSB_FIRST=1, word 0xA5A5_0F0F, LEN=31 → 32 bits in order 1,1,1,1,0,0,0,0,…; FIRST on bit 0, LAST on bit 31; first valid bit 2 cycles after accept.
- LSB_FIRST=0, word 0x8000_0001, LEN=7 → bits 1,0,0,0,0,0,0,0; SEL sequence 31..24; then IDLE.
- Back-to-back: words 0xFFFF_FFFF and 0x0000_0000, each with LEN=3, with IN_VALID held → 8 contiguous valid bits 1,1,1,1,0,0,0,0, no gap; IN_READY drops only while the shadow is full.
- CE low for 3 cycles mid-word (word 0x0000_00F0, LEN=7) → DOUT/SEL frozen; the sequence resumes without a lost or duplicated bit.
- RESETN low at bit 10 of a 32-bit word → DOUT_VALID=0 immediately; after release a new word with LEN=0 and data 0x1 emits a single bit 1 with FIRST=LAST=1.
